fp_min_pipe: RTL and testbench

Pipelined IEEE-754 minimumNumber unit for the min datapath. It takes two packed operands through a valid/ready handshake. It classifies each operand as zero, infinity, qNaN or sNaN, using the existing mantissa-zero check for the zero/infinity/NaN split. It then selects the minimum and returns a registered result with an invalid flag. Latency is 2 cycles and throughput is one result per cycle.

---
 rtl/fp_min_pkg.sv | 27 ++
 rtl/fp_min_class.sv | 39 +++
 rtl/zero_mant_chk.sv | 11 +
 rtl/fp_min_pipe.sv | 108 ++++++++++
 tb/tb_fp_min_pipe.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_min_pkg.sv
// Shared types and helpers for the pipelined IEEE-754 minimumNumber datapath.
package fp_min_pkg;

    localparam int MAX_FP_W = 64;

    typedef struct packed {
        logic zero;
        logic inf;
        logic qnan;
        logic snan;
    } fp_class_t;

    // Canonical qNaN: sign 0, exponent all-ones, mantissa MSB set, rest 0.
    function automatic logic [MAX_FP_W-1:0] canon_qnan(input int expo_w, input int mant_w);
        logic [MAX_FP_W-1:0] q;
        q = '0;
        for (int i = 0; i < MAX_FP_W; i++) begin
            if (i >= mant_w - 1 && i < mant_w + expo_w) q[i] = 1'b1;
        end
        return q;
    endfunction

    function automatic logic mag_lt(input logic [MAX_FP_W-1:0] a, input logic [MAX_FP_W-1:0] b);
        return a < b;
    endfunction

endpackage

// File: rtl/fp_min_class.sv
// Combinational operand classifier: zero / inf / qNaN / sNaN.
module fp_class
    import fp_min_pkg::*;
#(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic [SIGN_W-1:0] sign,
    input  logic [EXPO_W-1:0] expo,
    input  logic [MANT_W-1:0] mant,
    output fp_class_t         cls
);

    logic mant_zero;
    logic expo_ones;
    logic expo_zero;
    logic unused_sign;

    zero_mant_chk #(.MANT_W(MANT_W)) u_zero_mant_chk (
        .mant    (mant),
        .is_zero (mant_zero)
    );

    assign expo_ones   = &expo;
    assign expo_zero   = ~|expo;
    // Classes are sign-independent; the sign only matters at selection time.
    assign unused_sign = ^sign;

    // NOTE: every field gets a value on every path, so no latch is inferred.
    always_comb begin
        cls      = '0;
        cls.zero = expo_zero & mant_zero;
        cls.inf  = expo_ones & mant_zero;
        cls.qnan = expo_ones & ~mant_zero & mant[MANT_W-1];
        cls.snan = expo_ones & ~mant_zero & ~mant[MANT_W-1];
    end

endmodule

// File: rtl/zero_mant_chk.sv
// Mantissa-is-zero detector shared by the operand classifiers.
module zero_mant_chk #(
    parameter int MANT_W = 23
) (
    input  logic [MANT_W-1:0] mant,
    output logic              is_zero
);

    assign is_zero = ~|mant;

endmodule

// File: rtl/fp_min_pipe.sv
// Two-stage minimumNumber pipeline with valid/ready handshakes on both sides.
module fp_min_pipe
    import fp_min_pkg::*;
#(
    parameter  int SIGN_W = 1,
    parameter  int EXPO_W = 8,
    parameter  int MANT_W = 23,
    localparam int FP_W   = SIGN_W + EXPO_W + MANT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [FP_W-1:0] out_res,
    output logic            out_nv
);

    localparam int                  EM_W      = EXPO_W + MANT_W;
    localparam logic [MAX_FP_W-1:0] QNAN_WIDE = canon_qnan(EXPO_W, MANT_W);
    localparam logic [FP_W-1:0]     QNAN      = QNAN_WIDE[FP_W-1:0];

    fp_class_t       cls_a, cls_b;
    logic            s1_vld;
    logic [FP_W-1:0] s1_a, s1_b;
    fp_class_t       s1_ca, s1_cb;
    logic            s1_en, s2_en;

    logic                a_nan, b_nan, a_neg, b_neg;
    logic [MAX_FP_W-1:0] a_mag, b_mag;
    logic [FP_W-1:0]     sel_res;
    logic                unused_cls;

    fp_class #(.SIGN_W(SIGN_W), .EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_cls_a (
        .sign (in_a[FP_W-1 -: SIGN_W]),
        .expo (in_a[MANT_W +: EXPO_W]),
        .mant (in_a[MANT_W-1:0]),
        .cls  (cls_a)
    );

    fp_class #(.SIGN_W(SIGN_W), .EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_cls_b (
        .sign (in_b[FP_W-1 -: SIGN_W]),
        .expo (in_b[MANT_W +: EXPO_W]),
        .mant (in_b[MANT_W-1:0]),
        .cls  (cls_b)
    );

    assign s2_en  = ~out_vld | out_rdy;
    assign s1_en  = ~s1_vld | s2_en;
    assign in_rdy = s1_en;

    // Zero/inf are carried with the operands but the selection only needs the NaN split.
    assign unused_cls = ^{s1_ca.zero, s1_ca.inf, s1_cb.zero, s1_cb.inf};

    always_comb begin
        a_nan          = s1_ca.qnan | s1_ca.snan;
        b_nan          = s1_cb.qnan | s1_cb.snan;
        a_neg          = s1_a[FP_W-1];
        b_neg          = s1_b[FP_W-1];
        a_mag          = '0;
        b_mag          = '0;
        a_mag[EM_W-1:0] = s1_a[EM_W-1:0];
        b_mag[EM_W-1:0] = s1_b[EM_W-1:0];
        sel_res        = s1_a;
        if (a_nan && b_nan)   sel_res = QNAN;
        else if (a_nan)       sel_res = s1_b;
        else if (b_nan)       sel_res = s1_a;
        else if (a_neg != b_neg) sel_res = a_neg ? s1_a : s1_b;
        else if (!a_neg)      sel_res = mag_lt(b_mag, a_mag) ? s1_b : s1_a;
        else                  sel_res = mag_lt(a_mag, b_mag) ? s1_b : s1_a;
    end

    // NOTE: state is updated with non-blocking assignments so both stages see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: S1 data is cleared too so nothing stale is visible after reset.
            s1_vld  <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_ca   <= '0;
            s1_cb   <= '0;
            out_vld <= 1'b0;
            out_res <= '0;
            out_nv  <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_vld <= in_vld;
                if (in_vld) begin
                    s1_a  <= in_a;
                    s1_b  <= in_b;
                    s1_ca <= cls_a;
                    s1_cb <= cls_b;
                end
            end
            if (s2_en) begin
                out_vld <= s1_vld;
                if (s1_vld) begin
                    out_res <= sel_res;
                    out_nv  <= s1_ca.snan | s1_cb.snan;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_min_pipe.sv
// Scoreboard bench for fp_min_pipe: directed vectors, backpressure, throughput and reset.
module tb_fp_min_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld, in_rdy, out_vld, out_rdy, out_nv;
    logic [31:0] in_a, in_b, out_res;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [32:0] sb[$];
    int          inflight;
    bit          stalled;
    logic [32:0] held;
    int          run, max_run;

    localparam int NV = 11;
    localparam logic [31:0] VA [NV] = '{
        32'h3F800000, 32'h00000000, 32'hFF800000, 32'h7FC00000, 32'h7F800001, 32'h7FC00000,
        32'hFFC00001, 32'hBF800000, 32'h00000001, 32'h7F800000, 32'h40000000};
    localparam logic [31:0] VB [NV] = '{
        32'h40000000, 32'h80000000, 32'hC0000000, 32'h3F800000, 32'h40000000, 32'h7F800001,
        32'h7FC00000, 32'hC0000000, 32'h00000002, 32'hFF800000, 32'h7FA00000};
    localparam logic [32:0] VE [NV] = '{
        {1'b0, 32'h3F800000}, {1'b0, 32'h80000000}, {1'b0, 32'hFF800000}, {1'b0, 32'h3F800000},
        {1'b1, 32'h40000000}, {1'b1, 32'h7FC00000}, {1'b0, 32'h7FC00000}, {1'b0, 32'hC0000000},
        {1'b0, 32'h00000001}, {1'b0, 32'hFF800000}, {1'b1, 32'h40000000}};

    fp_min_pipe dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_a    (in_a),
        .in_b    (in_b),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_res (out_res),
        .out_nv  (out_nv)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp_v);
        n_total++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp_v);
    endtask

    // Reference minimumNumber for binary32, returns {nv, result}.
    function automatic logic [32:0] ref_min(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan, nv;
        logic [31:0] r;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        nv    = (a_nan && !a[22]) || (b_nan && !b[22]);
        if (a_nan && b_nan)      r = 32'h7FC00000;
        else if (a_nan)          r = b;
        else if (b_nan)          r = a;
        else if (a[31] != b[31]) r = a[31] ? a : b;
        else if (!a[31])         r = (b[30:0] < a[30:0]) ? b : a;
        else                     r = (a[30:0] < b[30:0]) ? b : a;
        return {nv, r};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r = {r[31], 8'hFF, 1'b1, r[21:0]};
            1: r = {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
            2: r = {r[31], 8'hFF, 23'h0};
            3: r = {r[31], 31'h0};
            default: ;
        endcase
        return r;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp_v);
        in_vld = 1'b1;
        in_a   = a;
        in_b   = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_rdy) begin
                sb.push_back(exp_v);
                @(posedge clk);
                #1;
                return;
            end
        end
        check("accept_timeout", in_rdy, 1);
        in_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        in_vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycle after acceptance: S1 only; the following cycle: result valid.
    task automatic latency_check(input string tag);
        in_vld = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, out_vld, 0);
        @(negedge clk);
        check({tag, "_lat2"}, out_vld, 1);
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    initial begin
        logic [32:0] exp_v;
        inflight = 0;
        stalled  = 1'b0;
        run      = 0;
        max_run  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                inflight = 0;
                stalled  = 1'b0;
                run      = 0;
            end else begin
                check("in_rdy", in_rdy, !(inflight == 2 && !out_rdy));
                if (out_vld) begin
                    if (stalled) check("stall_hold", {out_nv, out_res}, held);
                    if (out_rdy) begin
                        check("sb_nonempty", sb.size() != 0, 1);
                        if (sb.size() != 0) begin
                            exp_v = sb.pop_front();
                            check("out_res", out_res, exp_v[31:0]);
                            check("out_nv", out_nv, exp_v[32]);
                        end
                        run++;
                        if (run > max_run) max_run = run;
                    end else begin
                        run = 0;
                    end
                    stalled = !out_rdy;
                    held    = {out_nv, out_res};
                end else begin
                    stalled = 1'b0;
                    run     = 0;
                end
                if (in_vld && in_rdy) inflight++;
                if (out_vld && out_rdy) inflight--;
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_a    = '0;
        in_b    = '0;
        out_rdy = 1'b1;
        #1;
        check("rst_out_vld", out_vld, 0);
        check("rst_out_res", out_res, 0);
        check("rst_out_nv", out_nv, 0);
        check("rst_in_rdy", in_rdy, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors; the first one also checks latency from an empty pipe.
        send(VA[0], VB[0], VE[0]);
        latency_check("first");
        idle(2);
        for (int i = 1; i < NV; i++) send(VA[i], VB[i], VE[i]);
        idle(4);

        // Random pairs under pseudo-random backpressure.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    ra = rand_op();
                    rb = rand_op();
                    send(ra, rb, ref_min(ra, rb));
                end
                in_vld = 1'b0;
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    out_rdy = 1'($urandom_range(0, 1));
                end
                out_rdy = 1'b1;
            end
        join
        idle(6);

        // Full throughput: 16 back-to-back pairs with no backpressure.
        max_run = 0;
        for (int i = 0; i < 16; i++) send(VA[i % NV], VB[i % NV], VE[i % NV]);
        idle(5);
        check("throughput_run", max_run, 16);

        // Reset with both stages full.
        out_rdy = 1'b0;
        send(VA[1], VB[1], VE[1]);
        send(VA[2], VB[2], VE[2]);
        in_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_vld", out_vld, 0);
        check("midrst_out_res", out_res, 0);
        check("midrst_in_rdy", in_rdy, 1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_in_rdy", in_rdy, 1);
        out_rdy = 1'b1;
        idle(6);
        send(VA[7], VB[7], VE[7]);
        latency_check("postrst");
        idle(3);

        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        check("drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
